cvxif_coproc_responder: RTL and testbench

// - Responder (coprocessor) end of the CV-X-IF offload interface; the core is the initiator.
// - Decodes custom-3 instructions and computes results at issue.
// - Buffers results in a small in-order queue until the core commits or kills them.
// - Returns results in issue order over a valid/ready result channel.

---
 rtl/cvxif_rsp_pkg.sv | 33 +++
 rtl/cvxif_coproc_responder_if.sv | 43 ++++
 rtl/cvxif_rsp_decoder.sv | 66 ++++++
 rtl/cvxif_coproc_responder.sv | 163 ++++++++++++++++
 tb/tb_cvxif_coproc_responder.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cvxif_rsp_pkg.sv
// cvxif_rsp_pkg -- shared types for the CV-X-IF coprocessor responder.
//   OPCODE_CUSTOM3 : major opcode claimed by this coprocessor
//   funct3_e       : custom-3 operations (CADD/CSUB/CXOR/CNOP)
//   entry_t        : one pending-instruction queue slot
// entry_t is sized by XLEN_DEF/ID_W_DEF; the top's XLEN/IdWidth parameters
// default to these and must be kept equal to them.
package cvxif_rsp_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned ID_W_DEF = 3;

  localparam logic [6:0] OPCODE_CUSTOM3 = 7'h7B;
  localparam logic [6:0] FUNCT7_BASE    = 7'h00;

  typedef enum logic [2:0] {
    CADD = 3'b000,
    CSUB = 3'b001,
    CXOR = 3'b010,
    CNOP = 3'b011
  } funct3_e;

  // wb: operation produces a result (not CNOP); we: wb and rd != x0
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [4:0]          rd;
    logic                wb;
    logic                we;
    logic [XLEN_DEF-1:0] data;
    logic                committed;
    logic                killed;
  } entry_t;

endpackage

// File: rtl/cvxif_coproc_responder_if.sv
// cvxif_coproc_responder_if -- issue / commit / result channels between the
// core (master modport) and the coprocessor responder (slave modport).
//   issue_*  : offload request with operands, accept/writeback answer
//   commit_* : retire or kill message for an outstanding id
//   result_* : in-order valid/ready result channel back to the core
interface cvxif_coproc_responder_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IdWidth = 3
);

  logic               issue_valid_i;
  logic               issue_ready_o;
  logic [31:0]        issue_instr_i;
  logic [IdWidth-1:0] issue_id_i;
  logic [XLEN-1:0]    issue_rs1_i;
  logic [XLEN-1:0]    issue_rs2_i;
  logic               issue_accept_o;
  logic               issue_writeback_o;
  logic               commit_valid_i;
  logic [IdWidth-1:0] commit_id_i;
  logic               commit_kill_i;
  logic               result_valid_o;
  logic               result_ready_i;
  logic [IdWidth-1:0] result_id_o;
  logic [XLEN-1:0]    result_data_o;
  logic [4:0]         result_rd_o;
  logic               result_we_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
           commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
           result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
           commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
           result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

endinterface

// File: rtl/cvxif_rsp_decoder.sv
// cvxif_rsp_decoder -- combinational custom-3 decode and ALU.
//   instr_i      : instruction word
//   rs1_i/rs2_i  : source operands
//   accept_o     : instruction belongs to this coprocessor
//   writeback_o  : accepted instruction writes rd (all but CNOP)
//   rd_o         : destination register field
//   data_o       : result, arithmetic modulo 2^XLEN
module cvxif_rsp_decoder
  import cvxif_rsp_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            accept_o,
  output logic            writeback_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] data_o
);

  funct3_e f3_s;
  logic    unused_rs_fields_s;

  // register-index fields are irrelevant: operands arrive by value
  assign unused_rs_fields_s = ^instr_i[24:15];
  assign rd_o               = instr_i[11:7];

  // Decode opcode/funct7/funct3 and compute the result in one pass.
  always_comb begin
    accept_o    = 1'b0;
    writeback_o = 1'b0;
    data_o      = '0;
    f3_s        = funct3_e'(instr_i[14:12]);
    if ((instr_i[6:0] == OPCODE_CUSTOM3) && (instr_i[31:25] == FUNCT7_BASE)) begin
      case (f3_s)
        CADD: begin
          accept_o    = 1'b1;
          writeback_o = 1'b1;
          data_o      = rs1_i + rs2_i;
        end
        CSUB: begin
          accept_o    = 1'b1;
          writeback_o = 1'b1;
          data_o      = rs1_i - rs2_i;
        end
        CXOR: begin
          accept_o    = 1'b1;
          writeback_o = 1'b1;
          data_o      = rs1_i ^ rs2_i;
        end
        CNOP: begin
          accept_o    = 1'b1;
          writeback_o = 1'b0;
        end
        default: begin
          accept_o    = 1'b0;
          writeback_o = 1'b0;
        end
      endcase
    end else begin
      accept_o = 1'b0;
    end
  end

endmodule

// File: rtl/cvxif_coproc_responder.sv
// cvxif_coproc_responder -- CV-X-IF responder: decodes custom-3 at issue,
// keeps results in an in-order queue until commit/kill, returns them in
// issue order on the result channel.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : cvxif_coproc_responder_if.slave (issue/commit/result)
//   perf_accepted_o, perf_killed_o : present only with CVXIF_RSP_PERF_EN,
//                  wrapping counts of accepted issues and killed entries
module cvxif_coproc_responder
  import cvxif_rsp_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned NrEntries = 4,
  parameter int unsigned IdWidth   = ID_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  cvxif_coproc_responder_if.slave bus
`ifdef CVXIF_RSP_PERF_EN
  ,
  output logic [31:0] perf_accepted_o,
  output logic [31:0] perf_killed_o
`endif
);

  localparam int unsigned PtrW = $clog2(NrEntries);
  localparam int unsigned CntW = PtrW + 1;

  entry_t [NrEntries-1:0] q_q, q_d;
  logic   [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
  logic   [CntW-1:0]      count_q, count_d;

  logic            dec_accept_s, dec_wb_s;
  logic [4:0]      dec_rd_s;
  logic [XLEN-1:0] dec_data_s;
  logic            issue_ready_s, push_s, pop_s, hit_s, kill_hit_s, res_valid_s;
  logic [PtrW-1:0] hit_idx_s, idx_s;
  entry_t          head_e_s, new_e_s;

  cvxif_rsp_decoder #(.XLEN(XLEN)) u_dec (
    .instr_i     (bus.issue_instr_i),
    .rs1_i       (bus.issue_rs1_i),
    .rs2_i       (bus.issue_rs2_i),
    .accept_o    (dec_accept_s),
    .writeback_o (dec_wb_s),
    .rd_o        (dec_rd_s),
    .data_o      (dec_data_s)
  );

  // ready is from the registered count only: a same-cycle pop does not free a slot
  assign issue_ready_s          = (count_q < CntW'(NrEntries));
  assign bus.issue_ready_o      = issue_ready_s;
  assign bus.issue_accept_o     = bus.issue_valid_i & dec_accept_s;
  assign bus.issue_writeback_o  = bus.issue_valid_i & dec_accept_s & dec_wb_s;

  assign head_e_s    = q_q[head_q];
  assign res_valid_s = (count_q != '0) & head_e_s.committed & ~head_e_s.killed & head_e_s.wb;

  assign bus.result_valid_o = res_valid_s;
  assign bus.result_id_o    = res_valid_s ? head_e_s.id   : '0;
  assign bus.result_data_o  = res_valid_s ? head_e_s.data : '0;
  assign bus.result_rd_o    = res_valid_s ? head_e_s.rd   : 5'd0;
  assign bus.result_we_o    = res_valid_s ? head_e_s.we   : 1'b0;

  // Queue next state: commit matching, head pop, tail push.
  always_comb begin
    q_d        = q_q;
    head_d     = head_q;
    tail_d     = tail_q;
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    idx_s      = '0;
    push_s     = bus.issue_valid_i & issue_ready_s & dec_accept_s;
    new_e_s    = '{id: bus.issue_id_i, rd: dec_rd_s, wb: dec_wb_s,
                   we: dec_wb_s & (dec_rd_s != 5'd0), data: dec_data_s,
                   committed: 1'b0, killed: 1'b0};

    // Oldest live, still-open entry with the id; only registered entries are
    // searched, so an issue in the same cycle is never a candidate.
    for (int i = 0; i < NrEntries; i++) begin
      idx_s = head_q + PtrW'(i);
      if (!hit_s && (CntW'(i) < count_q) && (q_q[idx_s].id == bus.commit_id_i) &&
          !q_q[idx_s].committed && !q_q[idx_s].killed) begin
        hit_s     = 1'b1;
        hit_idx_s = idx_s;
      end else begin
        hit_s = hit_s;
      end
    end
    kill_hit_s = bus.commit_valid_i & hit_s & bus.commit_kill_i;

    if (bus.commit_valid_i && hit_s) begin
      if (bus.commit_kill_i) begin
        q_d[hit_idx_s].killed = 1'b1;
      end else begin
        q_d[hit_idx_s].committed = 1'b1;
      end
    end else begin
      q_d = q_d;
    end

    // Killed heads and committed CNOPs leave silently; real results wait for ready.
    pop_s = (count_q != '0) &
            (head_e_s.killed | (head_e_s.committed & (~head_e_s.wb | bus.result_ready_i)));
    if (pop_s) begin
      q_d[head_q] = '0;
      head_d      = head_q + PtrW'(1);
    end else begin
      head_d = head_q;
    end

    if (push_s) begin
      q_d[tail_q] = new_e_s;
      tail_d      = tail_q + PtrW'(1);
    end else begin
      tail_d = tail_q;
    end

    count_d = count_q + CntW'(push_s) - CntW'(pop_s);
  end

  // Queue state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q     <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef CVXIF_RSP_PERF_EN
  logic [31:0] perf_acc_q, perf_acc_d, perf_kill_q, perf_kill_d;

  // Performance counter increments (wrap naturally at 2^32).
  always_comb begin
    perf_acc_d  = perf_acc_q + 32'(push_s);
    perf_kill_d = perf_kill_q + 32'(kill_hit_s);
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_acc_q  <= 32'd0;
      perf_kill_q <= 32'd0;
    end else begin
      perf_acc_q  <= perf_acc_d;
      perf_kill_q <= perf_kill_d;
    end
  end

  assign perf_accepted_o = perf_acc_q;
  assign perf_killed_o   = perf_kill_q;
`else
  logic unused_kill_hit_s;
  assign unused_kill_hit_s = kill_hit_s;
`endif

endmodule

// File: tb/tb_cvxif_coproc_responder.sv
// Bench for cvxif_coproc_responder: directed scenarios plus randomized
// traffic, checked through an in-order expected-result queue filled by a
// behavioural model and drained by an independent result monitor.
module tb_cvxif_coproc_responder;

  localparam int XLEN = 64;
  localparam int NR   = 4;
  localparam int IDW  = 3;

  logic clk;
  logic rst;

  cvxif_coproc_responder_if #(.XLEN(XLEN), .IdWidth(IDW)) bus ();

`ifdef CVXIF_RSP_PERF_EN
  logic [31:0] perf_acc;
  logic [31:0] perf_kill;
`endif

  cvxif_coproc_responder #(.XLEN(XLEN), .NrEntries(NR), .IdWidth(IDW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef CVXIF_RSP_PERF_EN
    ,
    .perf_accepted_o (perf_acc),
    .perf_killed_o   (perf_kill)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model entry: st 0 = waiting for commit, 1 = committed, 2 = killed
  typedef struct {
    logic [2:0]  id;
    logic [4:0]  rd;
    bit          wb;
    logic [63:0] data;
    int          st;
  } ment_t;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] data;
    logic [4:0]  rd;
    bit          we;
  } res_t;

  ment_t mq[$];
  res_t  exp_q[$];
  int    vectors;
  int    miscompares;
  int    acc_cnt;
  int    kill_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics of the custom-3 instruction set.
  function automatic void ref_decode(input logic [31:0] ins, input logic [63:0] a,
                                     input logic [63:0] b, output bit acc, output bit wb,
                                     output logic [63:0] d);
    int f3;
    f3  = int'(ins[14:12]);
    acc = (ins[6:0] == 7'h7B) && (ins[31:25] == 7'h00) && (f3 < 4);
    wb  = acc && (f3 != 3);
    if (f3 == 0)      d = a + b;
    else if (f3 == 1) d = a - b;
    else if (f3 == 2) d = a ^ b;
    else              d = 64'd0;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    logic [9:0] rs;
    rs = 10'($urandom);
    return {f7, rs, f3, rd, opc};
  endfunction

  // One clock cycle: drive at negedge, check the issue answer, advance the model.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [2:0] iid,
                      input logic [63:0] a, input logic [63:0] b, input bit cv,
                      input logic [2:0] cid, input bit ck, input bit rr);
    bit hs, acc, wb;
    logic [63:0] d;
    ment_t t;
    res_t  r;
    @(negedge clk);
    bus.issue_valid_i  = iv;
    bus.issue_instr_i  = ins;
    bus.issue_id_i     = iid;
    bus.issue_rs1_i    = a;
    bus.issue_rs2_i    = b;
    bus.commit_valid_i = cv;
    bus.commit_id_i    = cid;
    bus.commit_kill_i  = ck;
    bus.result_ready_i = rr;
    #1;
    hs = iv && bus.issue_ready_o;
    ref_decode(ins, a, b, acc, wb, d);
    if (hs) begin
      chk("issue_accept", {63'd0, bus.issue_accept_o}, {63'd0, acc});
      chk("issue_writeback", {63'd0, bus.issue_writeback_o}, {63'd0, wb});
    end
    if (cv) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].id == cid && mq[i].st == 0) begin
          t = mq[i];
          t.st = ck ? 2 : 1;
          mq[i] = t;
          if (ck) kill_cnt++;
          break;
        end
      end
    end
    if (hs && acc) begin
      t.id = iid; t.rd = ins[11:7]; t.wb = wb; t.data = d; t.st = 0;
      mq.push_back(t);
      acc_cnt++;
    end
    while (mq.size() > 0 && mq[0].st != 0) begin
      t = mq.pop_front();
      if (t.st == 1 && t.wb) begin
        r.id = t.id; r.data = t.data; r.rd = t.rd; r.we = (t.rd != 5'd0);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 32'h0, 3'd0, 64'd0, 64'd0, 1'b0, 3'd0, 1'b0, rr);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [2:0] id, input logic [63:0] a,
                       input logic [63:0] b, input bit rr);
    step(1'b1, ins, id, a, b, 1'b0, 3'd0, 1'b0, rr);
  endtask

  task automatic commit(input logic [2:0] id, input bit kill, input bit rr);
    step(1'b0, 32'h0, 3'd0, 64'd0, 64'd0, 1'b1, id, kill, rr);
  endtask

  // Commit everything outstanding and wait, bounded, for every expected result.
  task automatic drain();
    int guard;
    guard = 0;
    while ((mq.size() > 0 || exp_q.size() > 0) && guard < 200) begin
      if (mq.size() > 0) commit(mq[0].id, 1'b0, 1'b1);
      else idle(1'b1);
      guard++;
    end
    chk("drain_outstanding", 64'(exp_q.size() + mq.size()), 64'd0);
    idle(1'b1);
    idle(1'b1);
  endtask

  // Result monitor: every completed result handshake must match the model's next result.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.result_valid_o === 1'b1 && bus.result_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_id", 64'(bus.result_id_o), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("result_id", 64'(bus.result_id_o), 64'(e.id));
          chk("result_data", bus.result_data_o, e.data);
          chk("result_rd", 64'(bus.result_rd_o), 64'(e.rd));
          chk("result_we", 64'(bus.result_we_o), 64'(e.we));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b;
    vectors = 0; miscompares = 0; acc_cnt = 0; kill_cnt = 0;
    bus.issue_valid_i = 1'b0; bus.issue_instr_i = 32'h0; bus.issue_id_i = 3'd0;
    bus.issue_rs1_i = 64'd0; bus.issue_rs2_i = 64'd0; bus.commit_valid_i = 1'b0;
    bus.commit_id_i = 3'd0; bus.commit_kill_i = 1'b0; bus.result_ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_issue_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("reset_result_valid", 64'(bus.result_valid_o), 64'd0);
    chk("reset_result_id", 64'(bus.result_id_o), 64'd0);
    chk("reset_result_data", bus.result_data_o, 64'd0);
    chk("reset_result_rd", 64'(bus.result_rd_o), 64'd0);
    chk("reset_result_we", 64'(bus.result_we_o), 64'd0);
    rst = 1'b0;

    // CADD 5+7 -> rd x10, result two cycles after issue
    issue(mk(7'h00, 3'b000, 5'd10, 7'h7B), 3'd2, 64'd5, 64'd7, 1'b1);
    commit(3'd2, 1'b0, 1'b0);
    chk("latency_t1_valid", 64'(bus.result_valid_o), 64'd0);
    idle(1'b1);
    chk("latency_t2_valid", 64'(bus.result_valid_o), 64'd1);
    chk("cadd_id", 64'(bus.result_id_o), 64'd2);
    chk("cadd_data", bus.result_data_o, 64'd12);
    chk("cadd_rd", 64'(bus.result_rd_o), 64'd10);
    chk("cadd_we", 64'(bus.result_we_o), 64'd1);
    idle(1'b1);

    // foreign opcode is rejected and never stored
    issue(mk(7'h00, 3'b000, 5'd3, 7'h33), 3'd4, 64'd1, 64'd1, 1'b1);
    chk("bad_opcode_accept", 64'(bus.issue_accept_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      commit(3'd4, 1'b0, 1'b1);
      chk("bad_opcode_no_result", 64'(bus.result_valid_o), 64'd0);
      chk("bad_opcode_ready", 64'(bus.issue_ready_o), 64'd1);
    end

    // ids 1,2,3; kill 2; commit 1,3 -> results 1 then 3
    for (int i = 1; i <= 3; i++) issue(mk(7'h00, 3'b000, 5'(i + 4), 7'h7B), 3'(i), 64'(i * 100), 64'd1, 1'b1);
    commit(3'd2, 1'b1, 1'b1);
    commit(3'd1, 1'b0, 1'b1);
    commit(3'd3, 1'b0, 1'b1);
    drain();

    // fill with uncommitted CSUB -> not ready; commit head -> ready after the pop
    for (int i = 0; i < NR; i++) issue(mk(7'h00, 3'b001, 5'd9, 7'h7B), 3'(i), 64'(i), 64'd50, 1'b1);
    commit(3'd0, 1'b0, 1'b1);
    chk("full_not_ready", 64'(bus.issue_ready_o), 64'd0);
    idle(1'b1);
    chk("full_head_valid", 64'(bus.result_valid_o), 64'd1);
    chk("full_still_not_ready", 64'(bus.issue_ready_o), 64'd0);
    idle(1'b1);
    chk("ready_after_pop", 64'(bus.issue_ready_o), 64'd1);
    drain();

    // back-pressure: payload holds for 5 cycles, pops on first ready
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    issue(mk(7'h00, 3'b010, 5'd7, 7'h7B), 3'd5, a, b, 1'b0);
    commit(3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("hold_valid", 64'(bus.result_valid_o), 64'd1);
      chk("hold_id", 64'(bus.result_id_o), 64'd5);
      chk("hold_data", bus.result_data_o, a ^ b);
      chk("hold_rd", 64'(bus.result_rd_o), 64'd7);
    end
    idle(1'b1);
    idle(1'b1);
    chk("hold_popped", 64'(bus.result_valid_o), 64'd0);

    // CXOR to x0 -> result with we=0
    issue(mk(7'h00, 3'b010, 5'd0, 7'h7B), 3'd6, 64'hF0, 64'h0F, 1'b0);
    commit(3'd6, 1'b0, 1'b0);
    idle(1'b1);
    chk("x0_valid", 64'(bus.result_valid_o), 64'd1);
    chk("x0_we", 64'(bus.result_we_o), 64'd0);
    drain();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r, sel;
      int pend[$];
      logic [31:0] ins;
      bit cv, ck;
      logic [2:0] cid;
      r = $urandom_range(0, 9);
      if (r == 0)      ins = mk(7'h00, 3'($urandom_range(0, 3)), 5'($urandom), 7'h33);
      else if (r == 1) ins = mk(7'h01, 3'($urandom_range(0, 3)), 5'($urandom), 7'h7B);
      else if (r == 2) ins = mk(7'h00, 3'($urandom_range(4, 7)), 5'($urandom), 7'h7B);
      else             ins = mk(7'h00, 3'($urandom_range(0, 3)), 5'($urandom), 7'h7B);
      foreach (mq[k]) if (mq[k].st == 0) pend.push_back(k);
      sel = $urandom_range(0, 9);
      cv = 1'b0; ck = 1'b0; cid = 3'd0;
      if (sel < 5 && pend.size() > 0) begin
        cv  = 1'b1;
        cid = mq[pend[$urandom_range(0, pend.size() - 1)]].id;
        ck  = ($urandom_range(0, 3) == 0);
      end else if (sel == 5) begin
        cv  = 1'b1;
        cid = 3'($urandom);
        ck  = $urandom_range(0, 1) == 1;
      end
      step($urandom_range(0, 9) < 6, ins, 3'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, cv, cid, ck, $urandom_range(0, 9) < 7);
    end
    drain();

`ifdef CVXIF_RSP_PERF_EN
    chk("perf_accepted", 64'(perf_acc), 64'(acc_cnt));
    chk("perf_killed", 64'(perf_kill), 64'(kill_cnt));
`endif

    // reset with three entries pending, one of them presenting a result
    for (int i = 0; i < 3; i++) issue(mk(7'h00, 3'b000, 5'd1, 7'h7B), 3'(i), 64'd3, 64'd4, 1'b0);
    commit(3'd0, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_reset_valid", 64'(bus.result_valid_o), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    exp_q.delete();
    #1;
    chk("mid_reset_valid", 64'(bus.result_valid_o), 64'd0);
    chk("mid_reset_ready", 64'(bus.issue_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 3; i++) begin
      commit(3'(i), 1'b0, 1'b1);
      chk("post_reset_no_result", 64'(bus.result_valid_o), 64'd0);
    end
    idle(1'b1);
    chk("post_reset_idle", 64'(bus.result_valid_o), 64'd0);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
